data_req_ctrl: RTL and testbench

DATA_REQ_CTRL -- requirements
Module: data_req_ctrl

---
 rtl/data_req_ctrl_pkg.sv | 30 +++
 rtl/data_req_ctrl_if.sv | 22 ++
 rtl/data_req_ctrl_req_size_enc.sv | 14 +
 rtl/data_req_ctrl.sv | 118 +++++++++++
 tb/tb_data_req_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_req_ctrl_pkg.sv
// Shared definitions for the data-side memory request controller:
// FSM encodings, bus size codes and the exception-vector width.
package data_req_ctrl_pkg;

    localparam int EXC_VEC_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Only 1, 2 or 4 enabled bytes ever arrive from the pipeline.
    function automatic logic [1:0] be_to_size(input logic [3:0] be);
        logic [2:0] n;
        n = {2'b0, be[0]} + {2'b0, be[1]} + {2'b0, be[2]} + {2'b0, be[3]};
        case (n)
            3'd2:    be_to_size = SIZE_HALF;
            3'd4:    be_to_size = SIZE_WORD;
            default: be_to_size = SIZE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/data_req_ctrl_if.sv
// Data-side SRAM-like bus: request channel plus address/data acknowledges.
interface data_req_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_req_ctrl_req_size_enc.sv
// Derives transfer size and direction from the EX-stage byte enables.
module req_size_enc
    import data_req_ctrl_pkg::*;
(
    input  logic [3:0] ren,
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic       wr
);

    assign wr   = |wen;
    assign size = be_to_size(wr ? wen : ren);

endmodule

// File: rtl/data_req_ctrl.sv
// Data memory request controller: issues one bus transaction per EX access,
// holds the pipeline while it is in flight and discards flushed responses.
//
// state | meaning
// IDLE  | no transaction; accept a new EX access
// REQ   | data_req asserted, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | response taken, waiting for the pipeline to advance
// DRAIN | flushed transaction, swallowing its response
module data_req_ctrl
    import data_req_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ex_data_en,
    input  logic [3:0]             ex_data_ren,
    input  logic [3:0]             ex_data_wen,
    input  logic [31:0]            ex_addr,
    input  logic [31:0]            ex_wdata,
    input  logic                   flush,
    input  logic                   pipe_stall,
    output logic                   stall_req,
    output logic [31:0]            mem_rdata,
    output logic                   mem_rdata_valid,
    data_req_ctrl_if.master        bus
);

    state_t     state;
    logic       kill;
    logic [1:0] enc_size;
    logic       enc_wr;

    req_size_enc u_size_enc (
        .ren  (ex_data_ren),
        .wen  (ex_data_wen),
        .size (enc_size),
        .wr   (enc_wr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            kill            <= 1'b0;
            bus.data_req    <= 1'b0;
            bus.data_wr     <= 1'b0;
            bus.data_size   <= SIZE_BYTE;
            bus.data_addr   <= '0;
            bus.data_wdata  <= '0;
            bus.data_wstrb  <= '0;
            mem_rdata       <= '0;
            mem_rdata_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_data_en && !flush) begin
                        state          <= ST_REQ;
                        kill           <= 1'b0;
                        bus.data_req   <= 1'b1;
                        bus.data_wr    <= enc_wr;
                        bus.data_size  <= enc_size;
                        bus.data_addr  <= ex_addr;
                        bus.data_wdata <= ex_wdata;
                        bus.data_wstrb <= ex_data_wen;
                    end
                end
                ST_REQ: begin
                    // The request cannot be withdrawn; a flush only marks it dead.
                    if (bus.data_addr_ok) begin
                        bus.data_req <= 1'b0;
                        kill         <= 1'b0;
                        state        <= (kill || flush) ? ST_DRAIN : ST_WAIT;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DONE;
                            if (!bus.data_wr) mem_rdata <= bus.data_rdata;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || !pipe_stall) state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (bus.data_data_ok) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (flush)
                mem_rdata_valid <= 1'b0;
            else if (state == ST_DONE && !pipe_stall)
                mem_rdata_valid <= !bus.data_wr;
            else if (!pipe_stall)
                mem_rdata_valid <= 1'b0;
        end
    end

    always_comb begin
        stall_req = 1'b0;
        case (state)
            ST_IDLE:  stall_req = ex_data_en && !flush;
            ST_REQ:   stall_req = kill ? ex_data_en : 1'b1;
            ST_WAIT:  stall_req = !bus.data_data_ok;
            ST_DONE:  stall_req = 1'b0;
            ST_DRAIN: stall_req = ex_data_en;
            default:  stall_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl with a transaction-level reference model.
module tb_data_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_data_en;
    logic [3:0]  ex_data_ren;
    logic [3:0]  ex_data_wen;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        pipe_stall;
    logic        stall_req;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    data_req_ctrl_if bus_if ();

    data_req_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_data_en      (ex_data_en),
        .ex_data_ren     (ex_data_ren),
        .ex_data_wen     (ex_data_wen),
        .ex_addr         (ex_addr),
        .ex_wdata        (ex_wdata),
        .flush           (flush),
        .pipe_stall      (pipe_stall),
        .stall_req       (stall_req),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .bus             (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked as issue/wait/done phases.
    bit          m_issue, m_wait, m_done, m_killed, m_valid, m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;
    logic [1:0]  m_size;
    logic        exp_stall;

    function automatic logic [1:0] size_of(input logic [3:0] be);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(be[i]);
        return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_issue <= 0; m_wait <= 0; m_done <= 0; m_killed <= 0; m_valid <= 0; m_wr <= 0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_strb <= '0; m_size <= '0;
        end else begin
            if (!m_issue && !m_wait && !m_done) begin
                if (ex_data_en && !flush) begin
                    m_issue  <= 1; m_killed <= 0;
                    m_addr   <= ex_addr; m_wdata <= ex_wdata; m_strb <= ex_data_wen;
                    m_wr     <= (ex_data_wen != 4'd0);
                    m_size   <= size_of((ex_data_wen != 4'd0) ? ex_data_wen : ex_data_ren);
                end
            end else if (m_issue) begin
                if (bus_if.data_addr_ok) begin
                    m_issue <= 0; m_wait <= 1; m_killed <= m_killed | flush;
                end else if (flush) m_killed <= 1;
            end else if (m_wait) begin
                if (bus_if.data_data_ok) begin
                    m_wait <= 0; m_killed <= 0;
                    if (!m_killed && !flush) begin
                        m_done <= 1;
                        if (!m_wr) m_rdata <= bus_if.data_rdata;
                    end
                end else if (flush) m_killed <= 1;
            end else begin
                if (flush || !pipe_stall) m_done <= 0;
            end
            if (flush) m_valid <= 0;
            else if (m_done && !pipe_stall) m_valid <= !m_wr;
            else if (!pipe_stall) m_valid <= 0;
        end
    end

    always_comb begin
        exp_stall = 1'b0;
        if (m_issue)     exp_stall = m_killed ? ex_data_en : 1'b1;
        else if (m_wait) exp_stall = m_killed ? ex_data_en : !bus_if.data_data_ok;
        else if (m_done) exp_stall = 1'b0;
        else             exp_stall = ex_data_en && !flush;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("data_req", 32'(bus_if.data_req), 32'(m_issue));
            chk("stall_req", 32'(stall_req), 32'(exp_stall));
            chk("mem_rdata", mem_rdata, m_rdata);
            chk("mem_rdata_valid", 32'(mem_rdata_valid), 32'(m_valid));
            if (m_issue) begin
                chk("data_addr", bus_if.data_addr, m_addr);
                chk("data_wdata", bus_if.data_wdata, m_wdata);
                chk("data_wstrb", 32'(bus_if.data_wstrb), 32'(m_strb));
                chk("data_wr", 32'(bus_if.data_wr), 32'(m_wr));
                chk("data_size", 32'(bus_if.data_size), 32'(m_size));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic ex(input logic en, input logic [3:0] ren, input logic [3:0] wen,
                      input logic [31:0] a, input logic [31:0] d);
        ex_data_en = en; ex_data_ren = ren; ex_data_wen = wen; ex_addr = a; ex_wdata = d;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        bus_if.data_addr_ok = aok; bus_if.data_data_ok = dok; bus_if.data_rdata = rd;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " data_req"}, 32'(bus_if.data_req), 32'd0);
        chk({tag, " data_wr"}, 32'(bus_if.data_wr), 32'd0);
        chk({tag, " data_size"}, 32'(bus_if.data_size), 32'd0);
        chk({tag, " data_addr"}, bus_if.data_addr, 32'd0);
        chk({tag, " data_wdata"}, bus_if.data_wdata, 32'd0);
        chk({tag, " data_wstrb"}, 32'(bus_if.data_wstrb), 32'd0);
        chk({tag, " mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, " mem_rdata_valid"}, 32'(mem_rdata_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
        ex(1'b1, 4'h0, 4'h0, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        cmp_on = 1'b1;
        #12;
        chk_reset_outputs("reset");
        chk("reset stall_req follows en", 32'(stall_req), 32'd1);
        step();
        ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        step();

        // Word read, best-case latency.
        ex(1'b1, 4'hF, 4'h0, 32'h8000_0010, 32'h0);
        mid(); chk("rd accept stall_req", 32'(stall_req), 32'd1);
        step(); bus(1'b1, 1'b0, 32'h0);
        mid(); chk("rd data_req", 32'(bus_if.data_req), 32'd1);
        chk("rd size word", 32'(bus_if.data_size), 32'd2);
        chk("rd addr", bus_if.data_addr, 32'h8000_0010);
        step(); bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        mid(); chk("rd stall_req low T+2", 32'(stall_req), 32'd0);
        step(); bus(1'b0, 1'b0, 32'h0); ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        mid(); chk("rd mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("rd valid in DONE", 32'(mem_rdata_valid), 32'd0);
        step(); mid(); chk("rd valid set", 32'(mem_rdata_valid), 32'd1);
        step(); mid(); chk("rd valid one cycle", 32'(mem_rdata_valid), 32'd0);
        step();

        // Byte write with addr_ok held off for three cycles.
        ex(1'b1, 4'h0, 4'b0100, 32'h0000_1002, 32'hA5A5_5A5A);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus(1'b1, 1'b0, 32'h0);
            mid();
            chk("wr data_req stable", 32'(bus_if.data_req), 32'd1);
            chk("wr size byte", 32'(bus_if.data_size), 32'd0);
            chk("wr wstrb", 32'(bus_if.data_wstrb), 32'h4);
            chk("wr data_wr", 32'(bus_if.data_wr), 32'd1);
            chk("wr addr stable", bus_if.data_addr, 32'h0000_1002);
            chk("wr wdata stable", bus_if.data_wdata, 32'hA5A5_5A5A);
            step();
        end
        bus(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(); bus(1'b0, 1'b0, 32'h0); ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("wr valid never", 32'(mem_rdata_valid), 32'd0);
            chk("wr mem_rdata kept", mem_rdata, 32'hDEAD_BEEF);
            step();
        end

        // Flush in WAIT -> DRAIN, then a new read, then DONE held by pipe_stall.
        ex(1'b1, 4'hF, 4'h0, 32'h0000_0040, 32'h0);
        step(); bus(1'b1, 1'b0, 32'h0);
        step(); bus(1'b0, 1'b0, 32'h0); flush = 1'b1; ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        step(); flush = 1'b0;
        mid(); chk("drain data_req", 32'(bus_if.data_req), 32'd0);
        chk("drain stall_req en=0", 32'(stall_req), 32'd0);
        step(); bus(1'b0, 1'b1, 32'h1234_5678); ex(1'b1, 4'hF, 4'h0, 32'h0000_0044, 32'h0);
        mid(); chk("drain stall_req en=1", 32'(stall_req), 32'd1);
        step(); bus(1'b0, 1'b0, 32'h0);
        mid(); chk("after drain mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("after drain valid", 32'(mem_rdata_valid), 32'd0);
        step(); bus(1'b1, 1'b0, 32'h0);
        mid(); chk("new req after drain", 32'(bus_if.data_req), 32'd1);
        chk("new req addr", bus_if.data_addr, 32'h0000_0044);
        step(); bus(1'b0, 1'b1, 32'h0BAD_F00D); pipe_stall = 1'b1;
        step(); bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("done no reissue", 32'(bus_if.data_req), 32'd0);
            chk("done stall_req", 32'(stall_req), 32'd0);
            chk("done valid held low", 32'(mem_rdata_valid), 32'd0);
            step();
        end
        pipe_stall = 1'b0; ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        mid(); chk("stalled mem_rdata", mem_rdata, 32'h0BAD_F00D);
        step(); mid(); chk("stalled valid set", 32'(mem_rdata_valid), 32'd1);
        step(); mid(); chk("stalled valid clear", 32'(mem_rdata_valid), 32'd0);
        step();

        // Half-word read flushed while still in REQ.
        ex(1'b1, 4'b0011, 4'h0, 32'h0000_0100, 32'h0);
        step(); flush = 1'b1; ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        mid(); chk("half size", 32'(bus_if.data_size), 32'd1);
        chk("kill cycle stall_req", 32'(stall_req), 32'd1);
        step(); flush = 1'b0; bus(1'b1, 1'b0, 32'h0);
        mid(); chk("killed req stall_req", 32'(stall_req), 32'd0);
        chk("killed req data_req", 32'(bus_if.data_req), 32'd1);
        step(); bus(1'b0, 1'b1, 32'h7777_7777);
        step(); bus(1'b0, 1'b0, 32'h0);
        mid(); chk("killed mem_rdata kept", mem_rdata, 32'h0BAD_F00D);
        chk("killed valid", 32'(mem_rdata_valid), 32'd0);
        step();

        // Flush coincident with data_ok in WAIT.
        ex(1'b1, 4'hF, 4'h0, 32'h0000_0200, 32'h0);
        step(); bus(1'b1, 1'b0, 32'h0);
        step(); bus(1'b0, 1'b1, 32'hCAFE_CAFE); flush = 1'b1; ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        step(); flush = 1'b0; bus(1'b0, 1'b0, 32'h0);
        mid(); chk("flush+ok mem_rdata", mem_rdata, 32'h0BAD_F00D);
        chk("flush+ok idle stall", 32'(stall_req), 32'd0);
        step(); mid(); chk("flush+ok valid", 32'(mem_rdata_valid), 32'd0);
        step();

        // Reset asserted while a write sits in REQ.
        ex(1'b1, 4'h0, 4'hF, 32'h0000_0300, 32'h1111_2222);
        step();
        mid(); chk("pre-reset data_req", 32'(bus_if.data_req), 32'd1);
        #2; resetn = 1'b0;
        #1; chk_reset_outputs("mid-reset");
        chk("mid-reset stall_req", 32'(stall_req), 32'd1);
        step(); ex(1'b0, 4'h0, 4'h0, 32'h0, 32'h0); resetn = 1'b1;
        step(); bus(1'b0, 1'b1, 32'h9999_9999);
        mid(); chk("late data_ok data_req", 32'(bus_if.data_req), 32'd0);
        chk("late data_ok stall", 32'(stall_req), 32'd0);
        step(); bus(1'b0, 1'b0, 32'h0);
        mid(); chk("late data_ok mem_rdata", mem_rdata, 32'h0);
        chk("late data_ok valid", 32'(mem_rdata_valid), 32'd0);
        step();

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
